// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: computes one round key per clock into an 11-entry store
// and serves them by index, with keys 0 and 10 also driven directly.
module aes_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic [3:0]   read_addr,
    output logic [127:0] round_key_input,
    output logic [127:0] round_key_0,
    output logic [127:0] round_key_10,
    output logic         keys_ready,
    output logic         busy
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state;
    logic [127:0] rk [NUM_ROUNDS+1];
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  t, w0, w1, w2, w3;

    // One full round of the word recurrence, derived from the previously written key
    always_comb begin
        prev_key = (rnd != 4'd0) ? rk[rnd - 4'd1] : '0;
        t        = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon, 24'h0};
        w0       = prev_key[127:96] ^ t;
        w1       = prev_key[95:64]  ^ w0;
        w2       = prev_key[63:32]  ^ w1;
        w3       = prev_key[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    assign round_key_input = (read_addr <= LAST) ? rk[read_addr] : '0;
    assign round_key_0     = rk[0];
    assign round_key_10    = rk[NUM_ROUNDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rnd        <= '0;
            rcon       <= 8'h01;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
        end else if (key_load) begin
            // A load restarts from any state, including mid-expansion
            state      <= EXPAND;
            rk[0]      <= key_in;
            rnd        <= 4'd1;
            rcon       <= 8'h01;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
        end else if (state == EXPAND) begin
            if (rnd <= LAST) begin
                rk[rnd] <= next_key;
                rcon    <= xtime(rcon);
                rnd     <= rnd + 4'd1;
                busy    <= 1'b1;
            end else begin
                state      <= READY;
                busy       <= 1'b0;
                keys_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomised bench for aes_key_schedule against a word-level FIPS-197 key expansion
// model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   read_addr = '0;
    logic [127:0] round_key_input, round_key_0, round_key_10;
    logic         keys_ready, busy;

    aes_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .read_addr(read_addr), .round_key_input(round_key_input),
        .round_key_0(round_key_0), .round_key_10(round_key_10),
        .keys_ready(keys_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int           total = 0;
    int           bad = 0;
    logic [7:0]   sb [256];
    logic [127:0] mk [11];
    int           since = -1;
    bit           chk_en = 1'b0;
    bit           rand_addr = 1'b1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] fips_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: cycles since the last sampled load, with the expanded key set it implies
    always @(posedge clk or posedge rst) begin
        if (rst) since = -1;
        else if (key_load) begin
            since = 0;
            for (int r = 0; r < 11; r++) mk[r] = fips_rk(key_in, r);
        end else if (since >= 0 && since < 1000) since++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 128'(busy), 128'(since >= 1 && since <= 10));
            chk("keys_ready", 128'(keys_ready), 128'(since >= 11));
            chk("rk0", round_key_0, (since >= 0) ? mk[0] : 128'h0);
            if (since < 0 || since >= 10)
                chk("rk10", round_key_10, (since < 0) ? 128'h0 : mk[10]);
            if (read_addr > 4'd10 || since < 0)
                chk("rk_read", round_key_input, 128'h0);
            else if (int'(read_addr) <= since)
                chk("rk_read", round_key_input, mk[read_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_addr) read_addr = 4'($urandom_range(0, 15));
    endtask

    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!keys_ready && n < 40) begin
            tick();
            n++;
        end
        chk(name, 128'(n), 128'd11);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int cnt;
        logic [127:0] kb;
        build_sbox();
        chk("model_k1_r1", fips_rk(K1, 1), K1R1);
        chk("model_k1_r10", fips_rk(K1, 10), K1R10);
        chk("model_k2_r10", fips_rk(K2, 10), K2R10);

        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_ready", 128'(keys_ready), 128'h0);
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_rk0", round_key_0, 128'h0);
        chk("reset_rk10", round_key_10, 128'h0);
        rst = 1'b0;
        tick();

        // FIPS-197 appendix A.1 key
        load(K1);
        wait_ready("latency_k1");
        chk("k1_rk0", round_key_0, K1);
        chk("k1_rk10", round_key_10, K1R10);
        rand_addr = 1'b0;
        read_addr = 4'd1;
        #1 chk("k1_rk1", round_key_input, K1R1);

        // Second key plus an address sweep
        load(K2);
        wait_ready("latency_k2");
        chk("k2_rk10", round_key_10, K2R10);
        for (int a = 0; a < 16; a++) begin
            read_addr = 4'(a);
            #1;
            if (a > 10) chk("sweep_zero", round_key_input, 128'h0);
            else chk("sweep_key", round_key_input, fips_rk(K2, a));
            tick();
        end
        rand_addr = 1'b1;

        // Reload during expansion
        load(rand_key());
        repeat (4) tick();
        kb = rand_key();
        load(kb);
        wait_ready("latency_restart");
        chk("restart_rk0", round_key_0, kb);
        chk("restart_rk10", round_key_10, fips_rk(kb, 10));

        // Asynchronous reset mid-expansion
        load(rand_key());
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'h0);
        chk("arst_ready", 128'(keys_ready), 128'h0);
        chk("arst_rk0", round_key_0, 128'h0);
        chk("arst_rk10", round_key_10, 128'h0);
        chk("arst_read", round_key_input, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        load(K1);
        wait_ready("latency_after_rst");
        chk("after_rst_rk10", round_key_10, K1R10);

        // Reload from READY
        load(K2);
        chk("reload_drop", 128'(keys_ready), 128'h0);
        cnt = 0;
        repeat (12) begin
            tick();
            if (busy) cnt++;
        end
        chk("reload_busy_cycles", 128'(cnt), 128'd10);
        chk("reload_ready", 128'(keys_ready), 128'h1);
        chk("reload_rk10", round_key_10, K2R10);

        // key_load held high for three cycles
        key_load = 1'b1;
        key_in = rand_key();
        tick();
        key_in = rand_key();
        tick();
        kb = rand_key();
        key_in = kb;
        tick();
        key_load = 1'b0;
        wait_ready("latency_held");
        chk("held_rk10", round_key_10, fips_rk(kb, 10));

        // Random keys with random gaps and occasional mid-expansion restarts
        for (int i = 0; i < 8; i++) begin
            load(rand_key());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 9)) tick();
                load(rand_key());
            end
            wait_ready("latency_rand");
            repeat ($urandom_range(1, 6)) tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
